// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-cell BIST controller.
package gate_bist_pkg;

    localparam int unsigned OBS_W = 8;

    typedef logic [OBS_W-1:0] obs_t;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int unsigned OBS_AND   = 0;
    localparam int unsigned OBS_OR    = 1;
    localparam int unsigned OBS_XOR   = 2;
    localparam int unsigned OBS_NAND  = 3;
    localparam int unsigned OBS_NOR   = 4;
    localparam int unsigned OBS_XNOR  = 5;
    localparam int unsigned OBS_NOT_A = 6;
    localparam int unsigned OBS_NOT_B = 7;

    // Golden response indexed by {a,b}; entry 0 sits in the low byte.
    localparam logic [3:0][OBS_W-1:0] EXP_TABLE = {8'h23, 8'h8E, 8'h4E, 8'hF8};

endpackage

// File: rtl/gate_bist_if.sv
// Handshake, result and gate-cell drive/observe signals of the BIST controller.
interface gate_bist_if #(
    parameter int unsigned ERR_W = 8
);
    import gate_bist_pkg::*;

    logic             start;
    logic             a_drv;
    logic             b_drv;
    obs_t             obs;
    logic             busy;
    logic             done;
    logic             pass;
    obs_t             fail_mask;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       first_fail;

    modport master (
        output start, obs,
        input  a_drv, b_drv, busy, done, pass, fail_mask, err_count, first_fail
    );

    modport slave (
        input  start, obs,
        output a_drv, b_drv, busy, done, pass, fail_mask, err_count, first_fail
    );

endinterface

// File: rtl/gate_bist_expect.sv
// Combinational golden-response lookup for one {a,b} vector.
module gate_bist_expect
    import gate_bist_pkg::*;
(
    input  logic [1:0] ab,
    output obs_t       exp_c
);

    always_comb begin
        exp_c = EXP_TABLE[ab];
    end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sweep controller: drives every {a,b} vector into the gate cell, checks all
// eight outputs against the golden table and accumulates sticky results.
module gate_bist_ctrl #(
    parameter int unsigned NUM_PASSES    = 1,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    gate_bist_if.slave  bus
);
    import gate_bist_pkg::*;

    localparam int unsigned SET_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SET_LAST  = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int unsigned PASS_W    = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int unsigned PASS_LAST = (NUM_PASSES > 0) ? NUM_PASSES - 1 : 0;

    state_t           state;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    obs_t             mask_q;
    logic [ERR_W-1:0] err_q;
    logic [1:0]       ff_q;
    logic [SET_W-1:0] settle_cnt;
    logic [PASS_W-1:0] pass_cnt;

    obs_t             exp_c;
    obs_t             diff_c;
    logic             mism_c;
    logic [ERR_W-1:0] err_nxt_c;
    logic             last_vec_c;

    gate_bist_expect u_expect (
        .ab    ({a_q, b_q}),
        .exp_c (exp_c)
    );

    // Compare the current vector and pre-compute the saturating error count.
    always_comb begin
        diff_c     = bus.obs ^ exp_c;
        mism_c     = |diff_c;
        err_nxt_c  = err_q;
        if (mism_c && !(&err_q)) begin
            err_nxt_c = err_q + ERR_W'(1);
        end
        last_vec_c = ({a_q, b_q} == 2'b11) && (pass_cnt == PASS_W'(PASS_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mask_q     <= '0;
            err_q      <= '0;
            ff_q       <= '0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= DRIVE;
                        busy_q     <= 1'b1;
                        a_q        <= 1'b0;
                        b_q        <= 1'b0;
                        pass_q     <= 1'b0;
                        mask_q     <= '0;
                        err_q      <= '0;
                        ff_q       <= '0;
                        settle_cnt <= '0;
                        pass_cnt   <= '0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= '0;
                    state      <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SET_W'(SET_LAST)) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                CHECK: begin
                    // err_q is zero until the first mismatch, since it saturates rather than wraps.
                    if (mism_c) begin
                        mask_q <= mask_q | diff_c;
                        err_q  <= err_nxt_c;
                        if (err_q == '0) begin
                            ff_q <= {a_q, b_q};
                        end
                    end
                    if (last_vec_c) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        pass_q <= (err_nxt_c == '0);
                        a_q    <= 1'b0;
                        b_q    <= 1'b0;
                    end else begin
                        state      <= DRIVE;
                        {a_q, b_q} <= {a_q, b_q} + 2'd1;
                        if ({a_q, b_q} == 2'b11) begin
                            pass_cnt <= pass_cnt + PASS_W'(1);
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_drv      = a_q;
    assign bus.b_drv      = b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_mask  = mask_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: a modelled gate cell with injectable faults
// feeds three controller configurations; predicted run results are queued and checked at done.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    typedef struct packed {
        logic       pass;
        logic [7:0] mask;
        logic [7:0] err;
        logic [1:0] ff;
    } res_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic [7:0] mask;
        logic [7:0] err;
        logic [1:0] ff;
        logic       a;
        logic       b;
    } snap_t;

    logic clk;
    logic rst_n;
    int   fault_mode;
    int   n_checks;
    int   n_err;
    res_t exp_q[$];
    logic [1:0] ref_ab;
    obs_t       ref_exp;

    gate_bist_if #(.ERR_W(8)) i0 ();
    gate_bist_if #(.ERR_W(4)) i1 ();
    gate_bist_if #(.ERR_W(8)) i2 ();

    gate_bist_ctrl #(.NUM_PASSES(1), .SETTLE_CYCLES(1), .ERR_W(8)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (i0.slave));
    gate_bist_ctrl #(.NUM_PASSES(8), .SETTLE_CYCLES(1), .ERR_W(4)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (i1.slave));
    gate_bist_ctrl #(.NUM_PASSES(1), .SETTLE_CYCLES(0), .ERR_W(8)) dut2 (
        .clk (clk), .rst_n (rst_n), .bus (i2.slave));

    gate_bist_expect u_ref_exp (.ab (ref_ab), .exp_c (ref_exp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural fault-free gate cell.
    function automatic obs_t gate_ref(input logic [1:0] ab);
        obs_t g;
        logic a;
        logic b;
        a = ab[1];
        b = ab[0];
        g = '0;
        g[OBS_AND]   = a & b;
        g[OBS_OR]    = a | b;
        g[OBS_XOR]   = a ^ b;
        g[OBS_NAND]  = ~(a & b);
        g[OBS_NOR]   = ~(a | b);
        g[OBS_XNOR]  = ~(a ^ b);
        g[OBS_NOT_A] = ~a;
        g[OBS_NOT_B] = ~b;
        return g;
    endfunction

    function automatic obs_t apply_fault(input obs_t g, input int mode);
        obs_t o;
        o = g;
        case (mode)
            1: o[0] = 1'b0;
            2: o[2] = ~o[2];
            3: o = '0;
            default: o = g;
        endcase
        return o;
    endfunction

    always_comb i0.obs = apply_fault(gate_ref({i0.a_drv, i0.b_drv}), fault_mode);
    always_comb i1.obs = apply_fault(gate_ref({i1.a_drv, i1.b_drv}), fault_mode);
    always_comb i2.obs = apply_fault(gate_ref({i2.a_drv, i2.b_drv}), fault_mode);

    function automatic res_t predict(input int mode, input int np, input int errmax);
        res_t r;
        int   errs;
        obs_t d;
        r    = '0;
        errs = 0;
        for (int p = 0; p < np; p++) begin
            for (int v = 0; v < 4; v++) begin
                d = apply_fault(gate_ref(2'(v)), mode) ^ gate_ref(2'(v));
                if (d != '0) begin
                    r.mask = r.mask | d;
                    if (errs == 0) r.ff = 2'(v);
                    if (errs < errmax) errs++;
                end
            end
        end
        r.err  = 8'(errs);
        r.pass = (errs == 0);
        return r;
    endfunction

    function automatic snap_t snap(input int id);
        snap_t s;
        case (id)
            1: s = '{i1.busy, i1.done, i1.pass, i1.fail_mask, {4'b0, i1.err_count},
                     i1.first_fail, i1.a_drv, i1.b_drv};
            2: s = '{i2.busy, i2.done, i2.pass, i2.fail_mask, i2.err_count,
                     i2.first_fail, i2.a_drv, i2.b_drv};
            default: s = '{i0.busy, i0.done, i0.pass, i0.fail_mask, i0.err_count,
                     i0.first_fail, i0.a_drv, i0.b_drv};
        endcase
        return s;
    endfunction

    task automatic set_start(input int id, input logic v);
        i0.start = (id == 0) ? v : 1'b0;
        i1.start = (id == 1) ? v : 1'b0;
        i2.start = (id == 2) ? v : 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete run on controller id; expected results come from the queue.
    task automatic run(input int id, input int mode, input int np, input int errmax,
                       input int lat, input bit repulse);
        res_t  r;
        snap_t s;
        int    cyc;
        int    busy_cnt;
        bit    got;
        fault_mode = mode;
        exp_q.push_back(predict(mode, np, errmax));
        set_start(id, 1'b1);
        @(posedge clk); #1;
        set_start(id, 1'b0);
        s = snap(id);
        chk("accept_busy", 32'(s.busy), 32'd1);
        chk("accept_ab", 32'({s.a, s.b}), 32'd0);
        chk("accept_clear", 32'({s.pass, s.mask, s.err, s.ff}), 32'd0);
        cyc = 0; busy_cnt = 0; got = 1'b0;
        while (cyc < 2000) begin
            s = snap(id);
            if (s.done) begin
                got = 1'b1;
                break;
            end
            if (s.busy) busy_cnt++;
            set_start(id, repulse && (cyc == 3));
            @(posedge clk); #1;
            cyc++;
        end
        set_start(id, 1'b0);
        chk("done_seen", 32'(got), 32'd1);
        chk("done_latency", 32'(cyc), 32'(lat));
        chk("busy_cycles", 32'(busy_cnt), 32'(lat));
        r = exp_q.pop_front();
        chk("done_busy", 32'(s.busy), 32'd0);
        chk("done_ab", 32'({s.a, s.b}), 32'd0);
        chk("pass", 32'(s.pass), 32'(r.pass));
        chk("fail_mask", 32'(s.mask), 32'(r.mask));
        chk("err_count", 32'(s.err), 32'(r.err));
        chk("first_fail", 32'(s.ff), 32'(r.ff));
        @(posedge clk); #1;
        s = snap(id);
        chk("post_done", 32'(s.done), 32'd0);
        chk("post_busy", 32'(s.busy), 32'd0);
        chk("hold_results", 32'({s.pass, s.mask, s.err, s.ff}), 32'(r));
        @(posedge clk); #1;
        s = snap(id);
        chk("no_relaunch", 32'(s.busy), 32'd0);
    endtask

    initial begin
        snap_t s;
        bit    seen_done;
        bit    reached;
        n_checks   = 0;
        n_err      = 0;
        fault_mode = 0;
        ref_ab     = 2'b00;
        rst_n      = 1'b0;
        set_start(0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            chk("reset_outputs", 32'(snap(id)), 32'd0);
        end
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            ref_ab = 2'(v);
            #1;
            chk("expect_table", 32'(ref_exp), 32'(gate_ref(2'(v))));
        end
        @(posedge clk); #1;

        run(0, 0, 1, 255, 12, 1'b0);
        run(0, 1, 1, 255, 12, 1'b0);
        run(0, 2, 1, 255, 12, 1'b0);
        run(1, 3, 8, 15, 96, 1'b0);

        // Abort a faulty run during vector 10 and confirm nothing survives.
        fault_mode = 2;
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        seen_done = 1'b0;
        reached   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            s = snap(0);
            if (s.done) seen_done = 1'b1;
            if ({s.a, s.b} == 2'b10) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("abort_reached_v10", 32'(reached), 32'd1);
        chk("abort_err_before_rst", 32'(snap(0).err), 32'd2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        s = snap(0);
        if (s.done) seen_done = 1'b1;
        chk("abort_outputs", 32'(s), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        s = snap(0);
        if (s.done) seen_done = 1'b1;
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_idle", 32'(s.busy), 32'd0);
        run(0, 0, 1, 255, 12, 1'b0);

        run(2, 0, 1, 255, 8, 1'b1);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
